// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I branch control slice.
// BHT encodings, opcodes and the recovery FSM state type.
package riscv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        IDLE,
        FLUSH
    } ctrl_state_e;

    function automatic logic [1:0] sat_upd(
        input logic [1:0] ctr,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != ST) nxt = ctr + 2'd1;
        if (!taken && ctr != SNT) nxt = ctr - 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// Async read port; one saturating update per cycle.
module bht_2bit
    import riscv_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    localparam int N = 2 ** IDX_W;

    logic [1:0] ctr_q [N];

    // Read returns the stored value, so a same-cycle update is not visible.
    assign rd_ctr_o = ctr_q[rd_idx_i];

    // Counter array: weak not-taken after reset, saturating update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= sat_upd(ctr_q[upd_idx_i], upd_taken_i);
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predict / resolve / recovery control for the 5-stage pipe.
// BHT lookup in IF, check in EX, redirect + flush sequencing.
module branch_predict_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_IDX_W    = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic             if_is_branch,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic             ex_jump,
    input  logic [XLEN-1:0]  ex_target,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    ctrl_state_e      state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic             redirect_q, redirect_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [1:0] rd_ctr;
    logic       idle, br, mis, jmp;
    logic       unused_pc;

    assign unused_pc = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0],
                         ex_pc[XLEN-1:BHT_IDX_W+2], ex_pc[1:0]};

    // Wrong-path EX inputs are ignored while recovering; a jump wins over a branch.
    assign idle = (state_q == IDLE);
    assign jmp  = idle & ex_valid & ex_is_jump;
    assign br   = idle & ex_valid & ex_is_branch & ~ex_is_jump;
    assign mis  = br & (ex_jump != ex_pred_taken);

    bht_2bit #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (if_pc[BHT_IDX_W+1:2]),
        .rd_ctr_o    (rd_ctr),
        .upd_en_i    (br),
        .upd_idx_i   (ex_pc[BHT_IDX_W+1:2]),
        .upd_taken_i (ex_jump)
    );

    assign pred_taken  = if_valid & if_is_branch & rd_ctr[1];
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush_if_id = (state_q == FLUSH);
    assign flush_id_ex = (state_q == FLUSH);
    assign busy        = (state_q != IDLE);
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    // Recovery state, redirect pulse and perf counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            flush_cnt_q   <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Next state: resolve in IDLE, count down the flush window in FLUSH.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (br) branch_cnt_d = branch_cnt_q + 1'b1;
                if (mis | jmp) begin
                    mispred_cnt_d = mispred_cnt_q + 1'b1;
                    redirect_d    = 1'b1;
                    redirect_pc_d = (ex_jump | jmp) ? ex_target
                                                    : ex_pc + XLEN'(4);
                    state_d       = FLUSH;
                    flush_cnt_d   = 3'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q == 3'd1) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with a scoreboard queue.
// A small BHT/FSM model pushes expectations; DUT outputs pop them.
module tb_branch_predict_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_is_branch;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid, ex_is_branch, ex_is_jump;
    logic [31:0] ex_pc, ex_target;
    logic        ex_pred_taken, ex_jump;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_if_id, flush_id_ex, busy;
    logic [15:0] branch_cnt, mispred_cnt;

    always #5 clk = ~clk;

    branch_predict_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_is_branch  (if_is_branch),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jump    (ex_is_jump),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .ex_jump       (ex_jump),
        .ex_target     (ex_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .busy          (busy),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    logic [31:0] sb_q [$];
    string       tag_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    logic [1:0]  bht_m [16];
    int          flush_left;
    logic [15:0] cb, cm;

    task automatic push(input string t, input logic [31:0] v);
        sb_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic chk(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty observed=%h expected=entry", obs);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
        flush_left = 0;
        cb = '0;
        cm = '0;
    endtask

    task automatic push_state();
        push("branch_cnt", {16'h0, cb});
        push("mispred_cnt", {16'h0, cm});
        push("flush_if_id", {31'h0, flush_left > 0});
        push("flush_id_ex", {31'h0, flush_left > 0});
        push("busy", {31'h0, flush_left > 0});
    endtask

    task automatic chk_state();
        chk({16'h0, branch_cnt});
        chk({16'h0, mispred_cnt});
        chk({31'h0, flush_if_id});
        chk({31'h0, flush_id_ex});
        chk({31'h0, busy});
    endtask

    task automatic lookup(input logic [31:0] pc);
        if_valid     = 1'b1;
        if_is_branch = 1'b1;
        if_pc        = pc;
        #1;
        push("pred_taken", {31'h0, bht_m[pc[5:2]][1]});
        chk({31'h0, pred_taken});
    endtask

    task automatic idle_cycle();
        if (flush_left > 0) flush_left--;
        push("redirect", 32'h0);
        push_state();
        tick();
        chk({31'h0, redirect});
        chk_state();
    endtask

    task automatic resolve(input logic br_i, input logic jp_i,
                           input logic [31:0] pc, input logic pr,
                           input logic jo, input logic [31:0] tgt,
                           input logic chk_if);
        logic       in_fl, b, j, m;
        logic [1:0] c;
        ex_valid      = 1'b1;
        ex_is_branch  = br_i;
        ex_is_jump    = jp_i;
        ex_pc         = pc;
        ex_pred_taken = pr;
        ex_jump       = jo;
        ex_target     = tgt;
        #1;
        if (chk_if) begin
            push("pred_same_cycle", {31'h0, bht_m[if_pc[5:2]][1]});
            chk({31'h0, pred_taken});
        end
        in_fl = flush_left > 0;
        j = !in_fl && jp_i;
        b = !in_fl && br_i && !jp_i;
        m = b && (jo != pr);
        if (b) begin
            c = bht_m[pc[5:2]];
            if (jo && c != 2'b11) c = c + 2'd1;
            if (!jo && c != 2'b00) c = c - 2'd1;
            bht_m[pc[5:2]] = c;
            cb = cb + 16'd1;
        end
        if (m || j) cm = cm + 16'd1;
        if (m || j) flush_left = FC;
        else if (flush_left > 0) flush_left--;
        push("redirect", {31'h0, m || j});
        if (m || j) push("redirect_pc", (jo || j) ? tgt : pc + 32'd4);
        push_state();
        tick();
        ex_valid = 1'b0;
        chk({31'h0, redirect});
        if (m || j) chk(redirect_pc);
        chk_state();
    endtask

    task automatic chk_reset_outputs();
        push("rst_redirect", 32'h0);
        push("rst_redirect_pc", 32'h0);
        push("rst_flush", 32'h0);
        push("rst_busy", 32'h0);
        push("rst_branch_cnt", 32'h0);
        push("rst_mispred_cnt", 32'h0);
        chk({31'h0, redirect});
        chk(redirect_pc);
        chk({30'h0, flush_if_id, flush_id_ex});
        chk({31'h0, busy});
        chk({16'h0, branch_cnt});
        chk({16'h0, mispred_cnt});
    endtask

    initial begin
        rst_n         = 1'b0;
        if_valid      = 1'b0;
        if_is_branch  = 1'b0;
        if_pc         = '0;
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_is_jump    = 1'b0;
        ex_pc         = '0;
        ex_pred_taken = 1'b0;
        ex_jump       = 1'b0;
        ex_target     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        tick();

        lookup(32'h100);
        if_is_branch = 1'b0;
        #1;
        push("pred_nonbranch", 32'h0);
        chk({31'h0, pred_taken});

        // training at 0x100
        resolve(1, 0, 32'h100, 0, 1, 32'h118, 0);
        idle_cycle();
        idle_cycle();
        lookup(32'h100);
        resolve(1, 0, 32'h100, 1, 1, 32'h118, 0);
        resolve(1, 0, 32'h100, 1, 1, 32'h118, 0);
        lookup(32'h100);
        resolve(1, 0, 32'h100, 1, 0, 32'h0, 0);
        idle_cycle();
        idle_cycle();
        lookup(32'h100);

        // not-taken mispredict
        resolve(1, 0, 32'h200, 1, 0, 32'h280, 0);
        idle_cycle();
        idle_cycle();

        // jal
        resolve(0, 1, 32'h40, 0, 0, 32'h30, 0);
        idle_cycle();
        idle_cycle();
        lookup(32'h40);

        // wrong-path suppression, then first IDLE cycle
        resolve(1, 0, 32'h200, 1, 0, 32'h0, 0);
        resolve(1, 0, 32'h300, 0, 1, 32'h400, 0);
        resolve(1, 0, 32'h300, 0, 1, 32'h400, 0);
        resolve(1, 0, 32'h300, 0, 1, 32'h400, 0);
        idle_cycle();
        idle_cycle();
        lookup(32'h300);

        // branch+jump both set counts as jump only
        resolve(1, 1, 32'h300, 1, 1, 32'h600, 0);
        idle_cycle();
        idle_cycle();
        lookup(32'h300);

        // pc+4 wrap
        resolve(1, 0, 32'hFFFF_FFFC, 1, 0, 32'h0, 0);
        idle_cycle();
        idle_cycle();

        // aliasing and same-cycle read/update
        if_valid     = 1'b1;
        if_is_branch = 1'b1;
        if_pc        = 32'h140;
        resolve(1, 0, 32'h100, 1, 0, 32'h0, 1);
        lookup(32'h140);
        idle_cycle();
        idle_cycle();

        // reset mid-flush
        resolve(0, 1, 32'h80, 0, 0, 32'h500, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_outputs();
        lookup(32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
